// File: rtl/cbd_poly_buffer.sv
// ---------------------------------------------------------------------------
// cbd_poly_buffer
//   Collects the signed CBD sampler stream (eta = 2) for the Kyber datapath.
//   Each coefficient is mapped into [0,Q), and 256-coefficient polynomials are
//   assembled in a two-bank ping-pong RAM. Each completed polynomial is then
//   offered to the NTT stage through a registered random-access read port and
//   a release handshake.
//
//   Optional build macro: CBD_POLY_BUF_RANGE_CHECK_EN
//     When defined, an accepted coefficient outside -ETA..+ETA is stored as 0
//     and sets the sticky err flag. When undefined, err is tied to 0.
//
// Ports
//   clk        in   rising-edge system clock
//   rst        in   asynchronous reset, active-high
//   in_valid   in   sampler presents in_coef
//   in_ready   out  buffer can accept (transfer on in_valid & in_ready)
//   in_coef    in   signed CBD coefficient, IN_W bits, two's complement
//   poly_valid out  the bank offered to the reader is full
//   poly_bank  out  index of the bank offered to the reader
//   rd_addr    in   coefficient index within the offered bank
//   rd_data    out  coefficient at rd_addr, one cycle of latency
//   rd_release in   one-cycle pulse: reader is done with the offered bank
//   err        out  sticky out-of-range flag (range-check build only)
// ---------------------------------------------------------------------------
module cbd_poly_buffer #(
    parameter int N      = 256,
    parameter int Q      = 3329,
    parameter int ETA    = 2,
    parameter int IN_W   = 3,
    parameter int COEF_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_coef,
    output logic              poly_valid,
    output logic              poly_bank,
    input  logic [7:0]        rd_addr,
    output logic [COEF_W-1:0] rd_data,
    input  logic              rd_release,
    output logic              err
);

    localparam int AW = $clog2(N);

    // Both banks live in one array; the bank index is the address MSB.
    logic [COEF_W-1:0] r_mem [0:2*N-1];

    logic [1:0]        r_full;        // per-bank FULL flag; FILLING is wb with wr_idx>0
    logic              r_wb;
    logic              r_rb;
    logic [AW-1:0]     r_wr_idx;
    logic              r_in_ready;
    logic              r_poly_valid;
    logic [COEF_W-1:0] r_rd_data;

    logic [1:0]        w_full_next;
    logic              w_wb_next;
    logic              w_rb_next;
    logic [AW-1:0]     w_wr_idx_next;
    logic              w_accept;
    logic              w_release;
    logic              w_rd_ok;
    logic [COEF_W:0]   w_ext;
    logic [COEF_W:0]   w_sum;
    logic [COEF_W-1:0] w_conv;
    logic [COEF_W-1:0] w_wdata;

    // Sign rule at COEF_W+1 bits: negative values get +Q, others pass through.
    assign w_ext  = {{(COEF_W+1-IN_W){in_coef[IN_W-1]}}, in_coef};
    assign w_sum  = in_coef[IN_W-1] ? (w_ext + (COEF_W+1)'(Q)) : w_ext;
    assign w_conv = COEF_W'(w_sum);

`ifdef CBD_POLY_BUF_RANGE_CHECK_EN
    localparam logic signed [COEF_W:0] L_ETA_POS = (COEF_W+1)'(ETA);
    localparam logic signed [COEF_W:0] L_ETA_NEG = -L_ETA_POS;

    logic w_bad;
    logic r_err;

    assign w_bad   = ($signed(w_ext) > L_ETA_POS) || ($signed(w_ext) < L_ETA_NEG);
    assign w_wdata = w_bad ? '0 : w_conv;
    assign err     = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_accept && w_bad) begin
            r_err <= 1'b1;
        end
    end
`else
    logic w_unused_eta;

    assign w_unused_eta = (ETA != 0);
    assign w_wdata      = w_conv;
    assign err          = 1'b0;
`endif

    // An 8-bit address can only exceed the bank when N is below 256.
    generate
        if (N < 256) begin : g_rd_range
            assign w_rd_ok = (rd_addr < 8'(N));
        end else begin : g_rd_full
            assign w_rd_ok = 1'b1;
        end
    endgenerate

    assign w_accept  = in_valid & r_in_ready;
    assign w_release = rd_release & r_poly_valid;

    always_comb begin
        w_full_next   = r_full;
        w_rb_next     = r_rb;
        w_wb_next     = r_wb;
        w_wr_idx_next = r_wr_idx;

        // Release is applied before the fill-completion decision so that a
        // bank finishing in the same cycle can hand over without a stall.
        if (w_release) begin
            w_full_next[r_rb] = 1'b0;
            w_rb_next         = ~r_rb;
        end

        if (w_accept) begin
            if (r_wr_idx == AW'(N-1)) begin
                w_wr_idx_next     = '0;
                w_full_next[r_wb] = 1'b1;
            end else begin
                w_wr_idx_next = r_wr_idx + 1'b1;
            end
        end

        // A full write bank moves to its sibling as soon as the sibling is empty.
        if (w_full_next[r_wb] && !w_full_next[~r_wb]) begin
            w_wb_next = ~r_wb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full       <= 2'b00;
            r_wb         <= 1'b0;
            r_rb         <= 1'b0;
            r_wr_idx     <= '0;
            r_in_ready   <= 1'b1;
            r_poly_valid <= 1'b0;
            r_rd_data    <= '0;
        end else begin
            r_full       <= w_full_next;
            r_wb         <= w_wb_next;
            r_rb         <= w_rb_next;
            r_wr_idx     <= w_wr_idx_next;
            r_in_ready   <= ~w_full_next[w_wb_next];
            r_poly_valid <= w_full_next[w_rb_next];
            r_rd_data    <= w_rd_ok ? r_mem[{r_rb, rd_addr[AW-1:0]}] : '0;
        end
    end

    // RAM write port; contents are deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[{r_wb, r_wr_idx}] <= w_wdata;
        end
    end

    assign in_ready   = r_in_ready;
    assign poly_valid = r_poly_valid;
    assign poly_bank  = r_rb;
    assign rd_data    = r_rd_data;

endmodule

// File: tb/tb_cbd_poly_buffer.sv
// ---------------------------------------------------------------------------
// tb_cbd_poly_buffer
//   Directed bench for cbd_poly_buffer: reset values, coefficient mapping,
//   ping-pong stall/release, fill/release collision, mid-fill reset and the
//   out-of-range behaviour for whichever build of the macro is compiled.
// ---------------------------------------------------------------------------
module tb_cbd_poly_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_coef;
    logic        poly_valid;
    logic        poly_bank;
    logic [7:0]  rd_addr;
    logic [11:0] rd_data;
    logic        rd_release;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_v [0:767];

    cbd_poly_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_coef    (in_coef),
        .poly_valid (poly_valid),
        .poly_bank  (poly_bank),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_release (rd_release),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic int conv(input int c);
        return (c < 0) ? c + 3329 : c;
    endfunction

    function automatic int pat(input int i, input int k);
        return ((i * k) % 5) - 2;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid   = 1'b0;
        in_coef    = 3'd0;
        rd_addr    = 8'd0;
        rd_release = 1'b0;
        rst        = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Present one coefficient and hold it until accepted (bounded wait).
    task automatic send(input int c, input logic rel, input logic chk_ready);
        int w;
        w        = 0;
        in_valid = 1'b1;
        in_coef  = 3'(c);
        if (chk_ready) check("in_ready_no_stall", in_ready, 1);
        while (in_ready !== 1'b1 && w < 2000) begin
            tick();
            w++;
        end
        check("send_not_timed_out", (w < 2000), 1);
        rd_release = rel;
        tick();
        in_valid   = 1'b0;
        rd_release = 1'b0;
    endtask

    // Stream n pattern coefficients, recording their expected stored values.
    task automatic stream(input int base, input int n, input int k, input logic chk_ready);
        for (int i = 0; i < n; i++) begin
            exp_v[base + i] = conv(pat(i, k));
            send(pat(i, k), 1'b0, chk_ready);
        end
    endtask

    task automatic read_check(input string tag, input int addr, input int expv);
        rd_addr = 8'(addr);
        tick();
        check(tag, rd_data, expv);
    endtask

    task automatic pulse_release();
        rd_release = 1'b1;
        tick();
        rd_release = 1'b0;
    endtask

    initial begin
        // ---------------- 1: reset values ----------------
        do_reset();
        $display("step reset: in_ready=%0d poly_valid=%0d err=%0d rd_data=%0d",
                 in_ready, poly_valid, err, rd_data);
        check("reset_in_ready", in_ready, 1);
        check("reset_poly_valid", poly_valid, 0);
        check("reset_poly_bank", poly_bank, 0);
        check("reset_err", err, 0);
        check("reset_rd_data", rd_data, 0);
        pulse_release();
        check("idle_release_ignored_bank", poly_bank, 0);
        check("idle_release_ignored_valid", poly_valid, 0);

        // ---------------- 2: mapping ----------------
        do_reset();
        stream(0, 256, 1, 1'b1);
        $display("step mapping: 256 coefs streamed, poly_valid=%0d poly_bank=%0d",
                 poly_valid, poly_bank);
        check("map_poly_valid", poly_valid, 1);
        check("map_poly_bank", poly_bank, 0);
        read_check("map_addr0", 0, 3327);
        read_check("map_addr1", 1, 3328);
        read_check("map_addr2", 2, 0);
        read_check("map_addr3", 3, 1);
        read_check("map_addr4", 4, 2);
        $display("step mapping: read addr 4 -> %0d", rd_data);

        // ---------------- 3: ping-pong stall and release ----------------
        do_reset();
        stream(0, 512, 3, 1'b1);
        $display("step pingpong: 512 coefs streamed, in_ready=%0d", in_ready);
        check("pp_in_ready_stalled", in_ready, 0);
        check("pp_poly_valid", poly_valid, 1);
        check("pp_poly_bank0", poly_bank, 0);
        read_check("pp_bank0_addr7", 7, exp_v[7]);
        pulse_release();
        $display("step pingpong: release -> poly_bank=%0d in_ready=%0d", poly_bank, in_ready);
        check("pp_rel_poly_bank", poly_bank, 1);
        check("pp_rel_poly_valid", poly_valid, 1);
        check("pp_rel_in_ready", in_ready, 1);
        read_check("pp_bank1_addr0", 0, exp_v[256]);
        read_check("pp_bank1_addr255", 255, exp_v[511]);

        // ---------------- 4: fill completion collides with release ----------------
        do_reset();
        stream(0, 256, 2, 1'b1);
        for (int i = 0; i < 256; i++) read_check("col_bank0_data", i, exp_v[i]);
        for (int i = 0; i < 255; i++) begin
            exp_v[256 + i] = conv(pat(i + 256, 2));
            send(pat(i + 256, 2), 1'b0, 1'b1);
        end
        exp_v[511] = conv(pat(511, 2));
        send(pat(511, 2), 1'b1, 1'b1);
        $display("step collision: 256th accept with release, in_ready=%0d poly_bank=%0d",
                 in_ready, poly_bank);
        check("col_in_ready_after", in_ready, 1);
        check("col_poly_bank", poly_bank, 1);
        check("col_poly_valid", poly_valid, 1);
        for (int i = 0; i < 256; i++) begin
            exp_v[512 + i] = conv(pat(i + 512, 2));
            send(pat(i + 512, 2), 1'b0, 1'b1);
        end
        for (int i = 0; i < 256; i++) read_check("col_bank1_data", i, exp_v[256 + i]);
        pulse_release();
        check("col_second_poly_bank", poly_bank, 0);
        check("col_second_poly_valid", poly_valid, 1);
        for (int i = 0; i < 256; i++) read_check("col_bank0b_data", i, exp_v[512 + i]);
        $display("step collision: 768 values read back");

        // ---------------- 5: reset mid-fill ----------------
        do_reset();
        stream(0, 256, 1, 1'b1);
        stream(256, 100, 3, 1'b1);
        check("mid_poly_valid_before", poly_valid, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_poly_valid", poly_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        tick();
        rst = 1'b0;
        tick();
        stream(0, 256, 4, 1'b1);
        $display("step midreset: fresh stream, poly_valid=%0d poly_bank=%0d", poly_valid, poly_bank);
        check("mid_fresh_poly_valid", poly_valid, 1);
        check("mid_fresh_poly_bank", poly_bank, 0);
        for (int i = 0; i < 256; i++) read_check("mid_fresh_data", i, exp_v[i]);

        // ---------------- 6: out-of-range input ----------------
        do_reset();
        for (int i = 0; i < 256; i++) begin
            if (i == 7) send(3, 1'b0, 1'b1);
            else        send(pat(i, 1), 1'b0, 1'b1);
        end
        read_check("oor_addr6", 6, conv(pat(6, 1)));
`ifdef CBD_POLY_BUF_RANGE_CHECK_EN
        read_check("oor_addr7", 7, 0);
        check("oor_err_set", err, 1);
        pulse_release();
        tick();
        check("oor_err_holds", err, 1);
`else
        read_check("oor_addr7", 7, 3);
        check("oor_err_zero", err, 0);
`endif
        read_check("oor_addr8", 8, conv(pat(8, 1)));
        $display("step range: addr 8 -> %0d err=%0d", rd_data, err);
        do_reset();
        check("oor_err_after_rst", err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
